// File: rtl/char_lcd_refresh.sv
// Self-timed HD44780 8-bit write-only driver: runs the init sequence once, then
// endlessly repaints a ROWS x COLS character buffer that user logic writes at any time.
module char_lcd_refresh #(
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned CLEAR_WAIT = 100000,
    parameter int unsigned AW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          init_done,
    output logic          frame_done,
    output logic [7:0]    lcd_db,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_e
);

    localparam int unsigned NCHAR  = ROWS * COLS;
    localparam int unsigned DEPTH  = 2 ** AW;
    localparam int unsigned STEP   = 2 * CLK_DIV;
    localparam int unsigned CNT_W  = (STEP > 2) ? $clog2(STEP) : 1;
    localparam int unsigned WAIT_W = (CLEAR_WAIT > 2) ? $clog2(CLEAR_WAIT) : 1;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 2;

    // State names the step to be loaded at the next step boundary, except
    // S_CLR (0x01 currently on the bus) and S_WAIT (post-clear idle).
    typedef enum logic [2:0] {
        S_INIT,
        S_CLR,
        S_WAIT,
        S_ADDR,
        S_CHAR
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         init_idx, init_idx_nx;
    logic [ROW_W-1:0]   row, row_nx;
    logic [COL_W-1:0]   col, col_nx;
    logic [AW-1:0]      pos, pos_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WAIT_W-1:0]  wcnt, wcnt_nx;

    logic [7:0]         db_nx;
    logic               rs_nx;
    logic               e_nx;
    logic               init_done_nx;
    logic               frame_done_nx;

    logic               load_c;
    logic               step_end_c;
    logic               half_c;
    logic               wait_end_c;
    logic [7:0]         init_cmd_c;
    logic [7:0]         row_base_c;

    logic [7:0]         mem [DEPTH];

    assign lcd_rw     = 1'b0;
    assign step_end_c = (cnt == CNT_W'(STEP - 1));
    assign half_c     = (cnt == CNT_W'(CLK_DIV - 1));
    assign wait_end_c = (wcnt == WAIT_W'(CLEAR_WAIT - 1));

    // Character buffer; a write on the clock a character is latched lands after the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= 8'h20;
            end
        end else if (wr_en && (32'(wr_addr) < NCHAR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and output registers; cnt starts at the step end so the first edge loads 0x38.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            init_idx   <= '0;
            row        <= '0;
            col        <= '0;
            pos        <= '0;
            cnt        <= CNT_W'(STEP - 1);
            wcnt       <= '0;
            lcd_db     <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            init_idx   <= init_idx_nx;
            row        <= row_nx;
            col        <= col_nx;
            pos        <= pos_nx;
            cnt        <= cnt_nx;
            wcnt       <= wcnt_nx;
            lcd_db     <= db_nx;
            lcd_rs     <= rs_nx;
            lcd_e      <= e_nx;
            init_done  <= init_done_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Step timing and sequencing.
    always_comb begin
        state_nx    = state;
        init_idx_nx = init_idx;
        row_nx      = row;
        col_nx      = col;
        pos_nx      = pos;
        cnt_nx      = cnt;
        wcnt_nx     = wcnt;
        load_c      = 1'b0;

        if (state == S_WAIT) begin
            if (wait_end_c) begin
                load_c = 1'b1;
            end else begin
                wcnt_nx = wcnt + WAIT_W'(1);
            end
        end else if (step_end_c) begin
            if (state == S_CLR) begin
                state_nx = S_WAIT;
                wcnt_nx  = '0;
            end else begin
                load_c = 1'b1;
            end
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end

        if (load_c) begin
            cnt_nx = '0;
            case (state)
                S_INIT, S_WAIT: begin
                    init_idx_nx = init_idx + 3'd1;
                    if (init_idx == 3'd2) begin
                        state_nx = (CLEAR_WAIT > 0) ? S_CLR : S_INIT;
                    end else if (init_idx >= 3'd4) begin
                        state_nx = S_ADDR;
                    end else begin
                        state_nx = S_INIT;
                    end
                end
                S_ADDR: begin
                    state_nx = S_CHAR;
                    col_nx   = '0;
                end
                S_CHAR: begin
                    pos_nx = pos + AW'(1);
                    col_nx = col + COL_W'(1);
                    if (col == COL_W'(COLS - 1)) begin
                        state_nx = S_ADDR;
                        col_nx   = '0;
                        if (row == ROW_W'(ROWS - 1)) begin
                            row_nx = '0;
                            pos_nx = '0;
                        end else begin
                            row_nx = row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus contents for the step being loaded, plus the enable waveform.
    always_comb begin
        db_nx         = lcd_db;
        rs_nx         = lcd_rs;
        e_nx          = lcd_e;
        init_done_nx  = init_done;
        frame_done_nx = 1'b0;

        case (init_idx)
            3'd0:    init_cmd_c = 8'h38;
            3'd1:    init_cmd_c = 8'h08;
            3'd2:    init_cmd_c = 8'h01;
            3'd3:    init_cmd_c = 8'h06;
            default: init_cmd_c = 8'h0C;
        endcase

        case (row)
            2'd0:    row_base_c = 8'h00;
            2'd1:    row_base_c = 8'h40;
            2'd2:    row_base_c = 8'(COLS);
            default: row_base_c = 8'(32'h40 + COLS);
        endcase

        if (load_c) begin
            e_nx = 1'b0;
            case (state)
                S_INIT, S_WAIT: begin
                    db_nx = init_cmd_c;
                    rs_nx = 1'b0;
                end
                S_ADDR: begin
                    db_nx         = 8'h80 | row_base_c;
                    rs_nx         = 1'b0;
                    init_done_nx  = 1'b1;
                    frame_done_nx = init_done && (row == '0);
                end
                S_CHAR: begin
                    db_nx = mem[pos];
                    rs_nx = 1'b1;
                end
                default: ;
            endcase
        end else if ((state == S_CLR) && step_end_c) begin
            e_nx = 1'b0;
        end else if ((state != S_WAIT) && half_c) begin
            e_nx = 1'b1;
        end
    end

endmodule
